lz77_match_finder: RTL and testbench

Downstream stage of the LZ77 input buffer. Pulls bytes one at a time with a `load` request and holds them in a lookahead buffer and a sliding dictionary window. Runs a serial greedy longest-match search and emits one LZ77 token (offset, length, next_char) per step over a valid/ready handshake to the token packer.

---
 rtl/lz77_match_finder.sv | 273 +++++++++++++++++++++++++++
 tb/tb_lz77_match_finder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lz77_match_finder.sv
// lz77_match_finder
// Serial greedy LZ77 match finder. Pulls bytes from the upstream input buffer
// one at a time, keeps them in a small lookahead buffer and a sliding
// dictionary window, and emits one (offset, length, next_char) token per step.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, num_bytes  stream start pulse and stream length (sampled on start)
//   data_in, load     byte from input buffer, one-cycle request for next byte
//   tok_valid/ready   token handshake towards the token packer
//   tok_offset        match distance 1..WIN, 0 for a literal
//   tok_len           match length 0..LA-1
//   tok_char          byte following the match
//   done              one-cycle pulse once the stream is fully tokenised
module lz77_match_finder #(
    parameter int WIN   = 8,
    parameter int LA    = 4,
    parameter int OFF_W = 4,
    parameter int LEN_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       num_bytes,
    input  logic [7:0]       data_in,
    output logic             load,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [OFF_W-1:0] tok_offset,
    output logic [LEN_W-1:0] tok_len,
    output logic [7:0]       tok_char,
    output logic             done
);
    localparam int WI_W = $clog2(WIN);
    localparam int LI_W = $clog2(LA);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL_REQ, S_FILL_CAP, S_SEARCH, S_EMIT, S_SHIFT, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       num_q, num_d;
    logic [4:0]       consumed_q, consumed_d;
    logic [4:0]       la_cnt_q, la_cnt_d;
    logic [4:0]       win_cnt_q, win_cnt_d;
    logic [4:0]       cur_off_q, cur_off_d;
    logic [4:0]       cur_l_q, cur_l_d;
    logic [4:0]       best_off_q, best_off_d;
    logic [4:0]       best_len_q, best_len_d;
    logic [4:0]       shift_cnt_q, shift_cnt_d;
    logic [7:0]       win_q [WIN];
    logic [7:0]       win_d [WIN];
    logic [7:0]       la_q [LA];
    logic [7:0]       la_d [LA];
    logic             load_q, load_d;
    logic             tok_valid_q, tok_valid_d;
    logic [OFF_W-1:0] tok_offset_q, tok_offset_d;
    logic [LEN_W-1:0] tok_len_q, tok_len_d;
    logic [7:0]       tok_char_q, tok_char_d;
    logic             done_q, done_d;

    // search datapath temporaries
    logic [WI_W-1:0]  src_idx_w_s;
    logic [LI_W-1:0]  src_idx_l_s;
    logic [7:0]       src_byte_s;
    logic [7:0]       tgt_byte_s;
    logic             match_s;
    logic             stop_s;
    logic [4:0]       match_len_s;
    logic [4:0]       nb_len_s;
    logic [4:0]       nb_off_s;

    // next-state and datapath logic for the whole FSM
    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        consumed_d   = consumed_q;
        la_cnt_d     = la_cnt_q;
        win_cnt_d    = win_cnt_q;
        cur_off_d    = cur_off_q;
        cur_l_d      = cur_l_q;
        best_off_d   = best_off_q;
        best_len_d   = best_len_q;
        shift_cnt_d  = shift_cnt_q;
        win_d        = win_q;
        la_d         = la_q;
        tok_valid_d  = tok_valid_q;
        tok_offset_d = tok_offset_q;
        tok_len_d    = tok_len_q;
        tok_char_d   = tok_char_q;
        done_d       = 1'b0;

        // Source byte: inside the window while l<o, else it runs into the
        // lookahead itself, which is what allows overlapping matches.
        src_idx_w_s = WI_W'(win_cnt_q - cur_off_q + cur_l_q);
        src_idx_l_s = LI_W'(cur_l_q - cur_off_q);
        src_byte_s  = (cur_l_q < cur_off_q) ? win_q[src_idx_w_s] : la_q[src_idx_l_s];
        tgt_byte_s  = la_q[LI_W'(cur_l_q)];
        match_s     = (src_byte_s == tgt_byte_s);
        match_len_s = match_s ? 5'(cur_l_q + 5'd1) : cur_l_q;
        // Length is capped at la_cnt-1 so tok_char always has a byte.
        stop_s      = !match_s || (5'(cur_l_q + 5'd1) == 5'(la_cnt_q - 5'd1));
        // Strictly longer wins; offsets ascend so ties keep the nearer one.
        nb_len_s    = (match_len_s > best_len_q) ? match_len_s : best_len_q;
        nb_off_s    = (match_len_s > best_len_q) ? cur_off_q : best_off_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d     = num_bytes;
                    win_cnt_d = 5'd0;
                    if (num_bytes == 5'd0) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        la_d[0]    = data_in;
                        la_cnt_d   = 5'd1;
                        consumed_d = 5'd1;
                        state_d    = S_FILL_REQ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL_REQ: begin
                if ((la_cnt_q < 5'(LA)) && (consumed_q < num_q)) begin
                    state_d = S_FILL_CAP;
                end else if (la_cnt_q == 5'd0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if ((win_cnt_q == 5'd0) || (la_cnt_q == 5'd1)) begin
                    // nothing to search: emit a literal straight away
                    best_len_d   = 5'd0;
                    best_off_d   = 5'd0;
                    tok_valid_d  = 1'b1;
                    tok_offset_d = {OFF_W{1'b0}};
                    tok_len_d    = {LEN_W{1'b0}};
                    tok_char_d   = la_q[0];
                    state_d      = S_EMIT;
                end else begin
                    cur_off_d  = 5'd1;
                    cur_l_d    = 5'd0;
                    best_len_d = 5'd0;
                    best_off_d = 5'd0;
                    state_d    = S_SEARCH;
                end
            end
            S_FILL_CAP: begin
                la_d[LI_W'(la_cnt_q)] = data_in;
                la_cnt_d   = 5'(la_cnt_q + 5'd1);
                consumed_d = 5'(consumed_q + 5'd1);
                state_d    = S_FILL_REQ;
            end
            S_SEARCH: begin
                best_len_d = nb_len_s;
                best_off_d = nb_off_s;
                if (stop_s) begin
                    if (cur_off_q == win_cnt_q) begin
                        tok_valid_d  = 1'b1;
                        tok_offset_d = (nb_len_s == 5'd0) ? {OFF_W{1'b0}} : OFF_W'(nb_off_s);
                        tok_len_d    = LEN_W'(nb_len_s);
                        tok_char_d   = la_q[LI_W'(nb_len_s)];
                        state_d      = S_EMIT;
                    end else begin
                        cur_off_d = 5'(cur_off_q + 5'd1);
                        cur_l_d   = 5'd0;
                    end
                end else begin
                    cur_l_d = 5'(cur_l_q + 5'd1);
                end
            end
            S_EMIT: begin
                if (tok_ready) begin
                    tok_valid_d  = 1'b0;
                    tok_offset_d = {OFF_W{1'b0}};
                    tok_len_d    = {LEN_W{1'b0}};
                    tok_char_d   = 8'd0;
                    shift_cnt_d  = 5'(best_len_q + 5'd1);
                    state_d      = S_SHIFT;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_SHIFT: begin
                // lookahead head moves to the window tail; oldest byte drops when full
                if (win_cnt_q == 5'(WIN)) begin
                    for (int i = 0; i < WIN - 1; i++) begin
                        win_d[i] = win_q[i + 1];
                    end
                    win_d[WIN-1] = la_q[0];
                end else begin
                    win_d[WI_W'(win_cnt_q)] = la_q[0];
                    win_cnt_d = 5'(win_cnt_q + 5'd1);
                end
                for (int i = 0; i < LA - 1; i++) begin
                    la_d[i] = la_q[i + 1];
                end
                la_d[LA-1]  = 8'd0;
                la_cnt_d    = 5'(la_cnt_q - 5'd1);
                shift_cnt_d = 5'(shift_cnt_q - 5'd1);
                if (shift_cnt_q == 5'd1) begin
                    state_d = S_FILL_REQ;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // load is registered, so it is decided on entry to FILL_REQ
        load_d = (state_d == S_FILL_REQ) && (la_cnt_d < 5'(LA)) && (consumed_d < num_d);
    end

    // state register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            num_q        <= 5'd0;
            consumed_q   <= 5'd0;
            la_cnt_q     <= 5'd0;
            win_cnt_q    <= 5'd0;
            cur_off_q    <= 5'd0;
            cur_l_q      <= 5'd0;
            best_off_q   <= 5'd0;
            best_len_q   <= 5'd0;
            shift_cnt_q  <= 5'd0;
            for (int i = 0; i < WIN; i++) begin
                win_q[i] <= 8'd0;
            end
            for (int i = 0; i < LA; i++) begin
                la_q[i] <= 8'd0;
            end
            load_q       <= 1'b0;
            tok_valid_q  <= 1'b0;
            tok_offset_q <= {OFF_W{1'b0}};
            tok_len_q    <= {LEN_W{1'b0}};
            tok_char_q   <= 8'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            consumed_q   <= consumed_d;
            la_cnt_q     <= la_cnt_d;
            win_cnt_q    <= win_cnt_d;
            cur_off_q    <= cur_off_d;
            cur_l_q      <= cur_l_d;
            best_off_q   <= best_off_d;
            best_len_q   <= best_len_d;
            shift_cnt_q  <= shift_cnt_d;
            win_q        <= win_d;
            la_q         <= la_d;
            load_q       <= load_d;
            tok_valid_q  <= tok_valid_d;
            tok_offset_q <= tok_offset_d;
            tok_len_q    <= tok_len_d;
            tok_char_q   <= tok_char_d;
            done_q       <= done_d;
        end
    end

    assign load       = load_q;
    assign tok_valid  = tok_valid_q;
    assign tok_offset = tok_offset_q;
    assign tok_len    = tok_len_q;
    assign tok_char   = tok_char_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lz77_match_finder.sv
// Directed testbench for lz77_match_finder (WIN=8, LA=4).
module tb_lz77_match_finder;
    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] num_bytes;
    logic [7:0] data_in;
    logic       load;
    logic       tok_valid;
    logic       tok_ready;
    logic [3:0] tok_offset;
    logic [1:0] tok_len;
    logic [7:0] tok_char;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int load_cnt = 0;
    int done_cnt = 0;
    int ptr      = 0;
    logic [7:0] mem [0:31];

    lz77_match_finder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_bytes  (num_bytes),
        .data_in    (data_in),
        .load       (load),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_offset (tok_offset),
        .tok_len    (tok_len),
        .tok_char   (tok_char),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // input buffer model: next byte appears the cycle after load
    initial begin
        forever begin
            @(posedge clk);
            if (load === 1'b1) begin
                ptr = ptr + 1;
                #1 data_in = mem[ptr];
            end
        end
    end

    // pulse counters for load and done
    initial begin
        forever begin
            @(posedge clk);
            if (load === 1'b1) load_cnt = load_cnt + 1;
            if (done === 1'b1) done_cnt = done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input string s);
        for (int i = 0; i < s.len(); i++) mem[i] = s[i];
        ptr     = 0;
        data_in = mem[0];
    endtask

    task automatic run_start(input logic [4:0] n);
        @(negedge clk);
        num_bytes = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic get_token(input string tag, input logic [3:0] e_off,
                             input logic [1:0] e_len, input logic [7:0] e_chr);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tok_valid === 1'b1) break;
        end
        check({tag, ".valid"}, 32'(tok_valid), 32'd1);
        check({tag, ".off"}, 32'(tok_offset), 32'(e_off));
        check({tag, ".len"}, 32'(tok_len), 32'(e_len));
        check({tag, ".chr"}, 32'(tok_char), 32'(e_chr));
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        @(negedge clk);
        check({tag, ".done_low"}, 32'(done), 32'd0);
    endtask

    int l0;
    int d0;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        num_bytes = 5'd0;
        data_in   = 8'd0;
        tok_ready = 1'b1;
        #1;
        check("rst.load", 32'(load), 32'd0);
        check("rst.valid", 32'(tok_valid), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.tok", {20'd0, tok_offset, tok_len, tok_char}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: ABABABA
        load_mem("ABABABA");
        l0 = load_cnt;
        d0 = done_cnt;
        run_start(5'd7);
        get_token("t1.k0", 4'd0, 2'd0, 8'h41);
        get_token("t1.k1", 4'd0, 2'd0, 8'h42);
        get_token("t1.k2", 4'd2, 2'd3, 8'h42);
        get_token("t1.k3", 4'd0, 2'd0, 8'h41);
        wait_done("t1");
        check("t1.loads", 32'(load_cnt - l0), 32'd6);
        check("t1.dones", 32'(done_cnt - d0), 32'd1);

        // 2: AAAAA, overlapping match
        load_mem("AAAAA");
        l0 = load_cnt;
        run_start(5'd5);
        get_token("t2.k0", 4'd0, 2'd0, 8'h41);
        get_token("t2.k1", 4'd1, 2'd3, 8'h41);
        wait_done("t2");
        check("t2.loads", 32'(load_cnt - l0), 32'd4);

        // 3: ten literals, final A lies beyond the window
        load_mem("ABCDEFGHIA");
        l0 = load_cnt;
        run_start(5'd10);
        for (int k = 0; k < 10; k++) begin
            get_token($sformatf("t3.k%0d", k), 4'd0, 2'd0, mem[k]);
        end
        wait_done("t3");
        check("t3.loads", 32'(load_cnt - l0), 32'd9);

        // 4: ABAB with a stall on the third token
        load_mem("ABAB");
        run_start(5'd4);
        get_token("t4.k0", 4'd0, 2'd0, 8'h41);
        get_token("t4.k1", 4'd0, 2'd0, 8'h42);
        @(negedge clk);
        tok_ready = 1'b0;
        get_token("t4.k2", 4'd2, 2'd1, 8'h42);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check($sformatf("t4.stall%0d", s),
                  {19'd0, tok_valid, tok_offset, tok_len, tok_char},
                  {19'd0, 1'b1, 4'd2, 2'd1, 8'h42});
        end
        tok_ready = 1'b1;
        wait_done("t4");

        // 5: reset during SEARCH of the third token, then restart with AB
        load_mem("ABABABA");
        run_start(5'd7);
        get_token("t5.k0", 4'd0, 2'd0, 8'h41);
        get_token("t5.k1", 4'd0, 2'd0, 8'h42);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5.rst", {29'd0, load, tok_valid, done}, 32'd0);
        d0 = done_cnt;
        @(negedge clk);
        @(negedge clk);
        check("t5.rst_hold", {29'd0, load, tok_valid, done}, 32'd0);
        rst = 1'b0;
        check("t5.no_done", 32'(done_cnt - d0), 32'd0);
        load_mem("AB");
        run_start(5'd2);
        get_token("t5.r0", 4'd0, 2'd0, 8'h41);
        get_token("t5.r1", 4'd0, 2'd0, 8'h42);
        wait_done("t5");

        // 6: empty stream
        l0 = load_cnt;
        run_start(5'd0);
        check("t6.done", 32'(done), 32'd1);
        check("t6.quiet", {30'd0, load, tok_valid}, 32'd0);
        @(negedge clk);
        check("t6.done_low", 32'(done), 32'd0);
        check("t6.loads", 32'(load_cnt - l0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
